// File: rtl/grf_wb.sv
// grf_wb: write-back side register file, 32 x 32-bit, two read ports.
// Optional same-cycle W->D bypass, plus a one-per-write commit log and counter.
module grf_wb #(
  parameter int          BYPASS   = 1,
  parameter logic [31:0] INIT_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE_W,
  input  logic [4:0]  A3_W,
  input  logic [31:0] WD_W,
  input  logic [31:0] PC_W,
  input  logic [4:0]  A1_D,
  input  logic [4:0]  A2_D,
  output logic [31:0] RD1_D,
  output logic [31:0] RD2_D,
  output logic        commit_valid,
  output logic [31:0] commit_pc,
  output logic [4:0]  commit_reg,
  output logic [31:0] commit_data,
  output logic [31:0] commit_count
);

  logic [31:0] r_regs [1:31];
  logic        r_valid;
  logic [31:0] r_pc;
  logic [4:0]  r_reg;
  logic [31:0] r_data;
  logic [31:0] r_count;

  logic        w_byp_en;
  logic        w_wr_nz;
  logic        w_byp1;
  logic        w_byp2;

  // bypass only forwards a live write outside reset
  assign w_byp_en = (BYPASS != 0) && reset && WE_W;
  assign w_wr_nz  = WE_W && (A3_W != 5'd0);
  assign w_byp1   = w_byp_en && (A3_W == A1_D);
  assign w_byp2   = w_byp_en && (A3_W == A2_D);

  // register array: reset to INIT_VAL, $0 is never stored
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= INIT_VAL;
      end
    end else if (w_wr_nz) begin
      r_regs[A3_W] <= WD_W;
    end
  end

  // read port 1: $0 is hardwired zero, otherwise bypass or array
  always_comb begin
    RD1_D = 32'h0;
    if (A1_D != 5'd0) begin
      RD1_D = w_byp1 ? WD_W : r_regs[A1_D];
    end
  end

  // read port 2: same rules as port 1
  always_comb begin
    RD2_D = 32'h0;
    if (A2_D != 5'd0) begin
      RD2_D = w_byp2 ? WD_W : r_regs[A2_D];
    end
  end

  // commit record: pulse per write, payload held when idle
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_pc    <= 32'h0;
      r_reg   <= 5'd0;
      r_data  <= 32'h0;
    end else begin
      r_valid <= WE_W;
      if (WE_W) begin
        r_pc   <= PC_W;
        r_reg  <= A3_W;
        r_data <= (A3_W == 5'd0) ? 32'h0 : WD_W;
      end
    end
  end

  // commit counter, wraps silently at 2^32
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= 32'h0;
    end else if (WE_W) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign commit_valid = r_valid;
  assign commit_pc    = r_pc;
  assign commit_reg   = r_reg;
  assign commit_data  = r_data;
  assign commit_count = r_count;

endmodule

// File: tb/tb_grf_wb.sv
// tb_grf_wb: directed bench for grf_wb, both bypass settings side by side.
// A register-file model is checked every cycle; literals pin key points.
module tb_grf_wb;

  localparam logic [31:0] INIT = 32'h1111_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  a3 = 5'd0;
  logic [31:0] wd = 32'h0;
  logic [31:0] pc = 32'h0;
  logic [4:0]  a1 = 5'd0;
  logic [4:0]  a2 = 5'd0;

  logic [31:0] rd1_0, rd2_0, cpc_0, cdata_0, ccnt_0;
  logic [4:0]  creg_0;
  logic        cv_0;
  logic [31:0] rd1_1, rd2_1, cpc_1, cdata_1, ccnt_1;
  logic [4:0]  creg_1;
  logic        cv_1;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;
  bit ld_req = 1'b0;
  int npulse;

  logic [31:0] m_regs [0:31];
  logic        m_valid;
  logic [31:0] m_pc;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic [31:0] m_count;

  always #5 clk = ~clk;

  grf_wb #(.BYPASS(0), .INIT_VAL(INIT)) dut0 (
    .clk(clk), .reset(reset), .WE_W(we), .A3_W(a3), .WD_W(wd),
    .PC_W(pc), .A1_D(a1), .A2_D(a2), .RD1_D(rd1_0), .RD2_D(rd2_0),
    .commit_valid(cv_0), .commit_pc(cpc_0), .commit_reg(creg_0),
    .commit_data(cdata_0), .commit_count(ccnt_0)
  );

  grf_wb #(.BYPASS(1), .INIT_VAL(INIT)) dut1 (
    .clk(clk), .reset(reset), .WE_W(we), .A3_W(a3), .WD_W(wd),
    .PC_W(pc), .A1_D(a1), .A2_D(a2), .RD1_D(rd1_1), .RD2_D(rd2_1),
    .commit_valid(cv_1), .commit_pc(cpc_1), .commit_reg(creg_1),
    .commit_data(cdata_1), .commit_count(ccnt_1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: architectural state after each posedge
  always @(posedge clk) begin
    logic [31:0] base;
    base = ld_req ? 32'hFFFF_FFFF : m_count;
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= (i == 0) ? 32'h0 : INIT;
      m_valid <= 1'b0;
      m_pc    <= 32'h0;
      m_reg   <= 5'd0;
      m_data  <= 32'h0;
      m_count <= 32'h0;
    end else begin
      m_valid <= we;
      m_count <= base + (we ? 32'd1 : 32'd0);
      if (we) begin
        m_pc   <= pc;
        m_reg  <= a3;
        m_data <= (a3 == 5'd0) ? 32'h0 : wd;
        if (a3 != 5'd0) m_regs[a3] <= wd;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && reset && we && a3 == a) return wd;
    return m_regs[a];
  endfunction

  // compare both instances against the model mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd1_nobyp", rd1_0, exp_rd(a1, 1'b0));
      chk("rd2_nobyp", rd2_0, exp_rd(a2, 1'b0));
      chk("rd1_byp", rd1_1, exp_rd(a1, 1'b1));
      chk("rd2_byp", rd2_1, exp_rd(a2, 1'b1));
      chk("cvalid0", {31'h0, cv_0}, {31'h0, m_valid});
      chk("cvalid1", {31'h0, cv_1}, {31'h0, m_valid});
      chk("cpc0", cpc_0, m_pc);
      chk("cpc1", cpc_1, m_pc);
      chk("creg0", {27'h0, creg_0}, {27'h0, m_reg});
      chk("creg1", {27'h0, creg_1}, {27'h0, m_reg});
      chk("cdata0", cdata_0, m_data);
      chk("cdata1", cdata_1, m_data);
      chk("ccnt0", ccnt_0, m_count);
      chk("ccnt1", ccnt_1, m_count);
    end
  end

  task automatic tick(input logic r, input logic w, input logic [4:0] d,
                      input logic [31:0] v, input logic [31:0] p,
                      input logic [4:0] x, input logic [4:0] y);
    @(posedge clk);
    #1;
    reset = r; we = w; a3 = d; wd = v; pc = p; a1 = x; a2 = y;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset with a write pending
    tick(1'b0, 1'b1, 5'd5, 32'hDEAD, 32'h0, 5'd5, 5'd5);
    chk_en = 1'b1;
    tick(1'b0, 1'b1, 5'd5, 32'hDEAD, 32'h0, 5'd5, 5'd5);
    chk("L_rst_rd_byp", rd1_1, INIT);
    chk("L_rst_cv", {31'h0, cv_0}, 32'h0);
    chk("L_rst_cnt", ccnt_1, 32'h0);

    // basic write $8, then read next cycle
    tick(1'b1, 1'b1, 5'd8, 32'h1234_5678, 32'h3000, 5'd8, 5'd0);
    chk("L_wr_old", rd1_0, INIT);
    chk("L_wr_byp", rd1_1, 32'h1234_5678);
    tick(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 5'd8, 5'd8);
    chk("L_wr_new", rd1_0, 32'h1234_5678);
    chk("L_wr_cpc", cpc_0, 32'h3000);
    chk("L_wr_creg", {27'h0, creg_0}, 32'd8);
    chk("L_wr_cnt", ccnt_0, 32'd1);

    // bypass to both ports
    tick(1'b1, 1'b1, 5'd9, 32'hCAFE, 32'h3004, 5'd9, 5'd9);
    chk("L_byp_rd1", rd1_1, 32'hCAFE);
    chk("L_byp_rd2", rd2_1, 32'hCAFE);
    chk("L_nobyp_rd1", rd1_0, INIT);

    // write to $0
    tick(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h3008, 5'd0, 5'd0);
    chk("L_z_rd", rd1_1, 32'h0);
    tick(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd9);
    chk("L_z_cv", {31'h0, cv_1}, 32'h1);
    chk("L_z_cdata", cdata_1, 32'h0);
    chk("L_z_cnt", ccnt_1, 32'd3);

    // five back-to-back writes, two idle cycles
    tick(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    npulse = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < 5)
        tick(1'b1, 1'b1, 5'(10 + i), 32'h100 + 32'(i), 32'h4000 + 32'(4 * i),
             5'(10 + i), 5'd10);
      else
        tick(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 5'd12, 5'd14);
      npulse += int'(cv_0);
    end
    chk("L_b2b_pulses", 32'(npulse), 32'd5);
    chk("L_b2b_cnt", ccnt_0, 32'd5);

    // counter wrap from preload
    #2;
    force dut0.r_count = 32'hFFFF_FFFF;
    force dut1.r_count = 32'hFFFF_FFFF;
    #1;
    release dut0.r_count;
    release dut1.r_count;
    ld_req = 1'b1;
    tick(1'b1, 1'b1, 5'd20, 32'h55, 32'h5000, 5'd0, 5'd0);
    ld_req = 1'b0;
    tick(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 5'd20, 5'd0);
    chk("L_wrap0", ccnt_0, 32'h0);
    chk("L_wrap1", ccnt_1, 32'h0);

    // mid-stream reset drops the pending write
    tick(1'b1, 1'b1, 5'd3, 32'h77, 32'h6000, 5'd3, 5'd0);
    tick(1'b0, 1'b1, 5'd3, 32'h88, 32'h6004, 5'd3, 5'd0);
    tick(1'b1, 1'b1, 5'd4, 32'h99, 32'h6008, 5'd3, 5'd4);
    chk("L_mr_reg3", rd1_0, INIT);
    chk("L_mr_cnt0", ccnt_0, 32'h0);
    tick(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd3);
    chk("L_mr_cnt1", ccnt_1, 32'd1);
    chk("L_mr_reg4", rd1_0, 32'h99);

    // mixed traffic on a few registers to exercise bypass hits
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           $urandom, 32'h7000 + 32'(4 * i), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)));
    end
    tick(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 5'd1, 5'd2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/grf_wb.md
# grf_wb

Write-back-side general register file for the 5-stage MIPS pipeline. It consumes the W-stage outputs of the MEM/WB pipeline register: write enable, destination register, write data and PC. It commits those values into 32 × 32-bit registers and serves the two D-stage read ports, with optional same-cycle W→D bypass. It also emits a registered, one-per-write commit record and a running commit count, which the bench uses for "@pc: $reg <= data" tracing.

## Interface
Parameters:
- BYPASS, 1, when 1 a same-cycle W-stage write to a read address is forwarded to RD1_D/RD2_D; when 0 reads return array contents only.
- INIT_VAL, 32'h0, value loaded into registers 1..31 on reset. Register 0 is always 0.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on posedge clk).
- WE_W  input  1  W-stage register write enable.
- A3_W  input  5  W-stage destination register number.
- WD_W  input  32  W-stage write data (ALUOut or ReadData, already selected).
- PC_W  input  32  PC of the W-stage instruction.
- A1_D  input  5  D-stage read address 1 (rs).
- A2_D  input  5  D-stage read address 2 (rt).
- RD1_D  output  32  read data 1, combinational.
- RD2_D  output  32  read data 2, combinational.
- commit_valid  output  1  registered pulse: a write was presented in the previous cycle.
- commit_pc  output  32  PC of the logged write.
- commit_reg  output  5  destination of the logged write.
- commit_data  output  32  value actually committed; 0 when commit_reg = 0.
- commit_count  output  32  number of commit_valid pulses since reset.

## Operation
- Array: regs[0..31]. regs[0] reads as 0 at all times and is never written.
- Write: on posedge clk with reset=1, WE_W=1 and A3_W≠0, set regs[A3_W] ← WD_W.
- Read: RDn_D = 0 if An_D=0.
  - Otherwise, with BYPASS=1, reset=1, WE_W=1 and A3_W=An_D: RDn_D = WD_W.
  - Otherwise: RDn_D = regs[An_D].
- Both ports are independent. A1_D=A2_D is legal and both return the same value.
- Commit log, updated every posedge with reset=1:
  - commit_valid ← WE_W.
  - When WE_W=1: commit_pc ← PC_W, commit_reg ← A3_W, commit_data ← (A3_W=0 ? 0 : WD_W).
  - When WE_W=0: commit_pc, commit_reg and commit_data hold their previous values.
- Counter: commit_count ← commit_count + 1 on each posedge where WE_W=1 and reset=1.
  - Modulo 2^32: 32'hFFFFFFFF wraps to 0 with no flag.
  - A write to $0 is logged and counted but not stored.
- Reset (reset=0 at posedge), regardless of WE_W:
  - regs[1..31] ← INIT_VAL.
  - commit_valid, commit_pc, commit_reg, commit_data and commit_count ← 0.
  - Write suppressed.
  - Bypass disabled while reset=0, so reads return regs contents.
- Reset values of outputs after the reset edge:
  - commit_* and commit_count are 0.
  - RD1_D/RD2_D return INIT_VAL for nonzero addresses and 0 for address 0.

## Timing
- Write latency: data presented at cycle n is in the array after posedge n.
  - BYPASS=0: a read of that address in cycle n returns the old value; it returns the new value from cycle n+1.
  - BYPASS=1: the new value is visible combinationally in cycle n.
- Read path is purely combinational: address to data within one cycle, no clock involvement.
- Commit record lags the W-stage write by exactly one cycle. commit_valid is high for one cycle per write.
- Back-to-back writes, one per cycle, produce back-to-back commit_valid pulses; the count increments every cycle.
- No handshake and no back-pressure: the block accepts one write per cycle unconditionally.
- Reset asserted mid-stream: the write presented at the reset edge is dropped and not counted. The first post-reset write is counted as 1.

## Test plan
- Reset: hold reset=0 for 2 cycles with WE_W=1, A3_W=5, WD_W=32'hDEAD → regs[5]=INIT_VAL, commit_valid=0, commit_count=0.
- Basic write/read with BYPASS=0: write $8←32'h1234_5678, PC_W=32'h3000 at cycle n.
  - RD1_D at A1_D=8 is the old value in cycle n and 32'h1234_5678 in cycle n+1.
  - Cycle n+1: commit_valid=1, commit_pc=32'h3000, commit_reg=8.
- Bypass with BYPASS=1: WE_W=1, A3_W=A1_D=A2_D=9, WD_W=32'hCAFE → both RD ports show 32'hCAFE in the same cycle.
- $0 handling: write $0←32'hFFFF_FFFF → RD at address 0 stays 0 and no bypass occurs; the next cycle shows commit_valid=1, commit_reg=0, commit_data=0, and count +1.
- Counter: 5 back-to-back writes then 2 idle cycles → commit_count=5 and commit_valid high for exactly 5 cycles. Forcing the counter preload to 32'hFFFFFFFF plus one write → 0.
- Mid-stream reset: reset=0 coincident with a write to $3 → $3=INIT_VAL and count=0; the next write yields count=1.
